rv32i_imem_responder: RTL and testbench
=======================================

Name: rv32i_imem_responder

Overview:
Responder side of the instruction-fetch interface: accepts fetch requests (PC) from the IF stage and returns the 32-bit instruction word after a configurable number of wait states, using valid/ready handshakes on both request and response. It replaces the zero-latency combinational instruction memory so that the fetch stage can be exercised against realistic memory latency. It also includes a program-load write port and a flush input, so that a taken branch or jump can discard an in-flight fetch.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit instruction words; the word index is ADDR[31:2].
WAIT_STATES, 1, extra cycles between request accept and response valid (0..15).
NOP_INST, 32'h00000013, word returned on fault and held on RSP_INST_OUT at reset (ADDI x0,x0,0).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
REQ_VALID_IN  input  1  fetch request valid
REQ_READY_OUT  output  1  responder can accept a request this cycle
REQ_ADDR_IN  input  32  byte address (PC) of the fetch
RSP_VALID_OUT  output  1  response valid
RSP_READY_IN  input  1  fetch stage accepts the response
RSP_INST_OUT  output  32  instruction word
RSP_ADDR_OUT  output  32  address the response belongs to
RSP_FAULT_OUT  output  1  misaligned or out-of-range fetch
FLUSH_IN  input  1  discard any in-flight or pending response
PROG_WE_IN  input  1  program-load write enable
PROG_ADDR_IN  input  32  program-load byte address; bits [1:0] ignored
PROG_DATA_IN  input  32  program-load data

Behaviour:
- Reset (async, rst=1):
  - state IDLE, wait counter 0.
  - RSP_VALID_OUT=0, RSP_INST_OUT=NOP_INST, RSP_ADDR_OUT=0, RSP_FAULT_OUT=0.
  - Memory array is not reset.
- States:
  - IDLE: no request held.
  - WAIT: counting down wait states.
  - RESP: response held, waiting for consumer.
- REQ_READY_OUT = !FLUSH_IN && (IDLE || (RESP && RSP_READY_IN)).
- Request accept = REQ_VALID_IN && REQ_READY_OUT. On accept:
  - Latch the address.
  - If WAIT_STATES=0, go to RESP next cycle (1-cycle latency).
  - Otherwise load the counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each cycle; when the counter is 0, go to RESP next cycle.
  - Total latency from accept edge to RSP_VALID_OUT=1 is WAIT_STATES+1 cycles.
- Entering RESP:
  - RSP_VALID_OUT=1, RSP_ADDR_OUT = latched address.
  - Fault if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS. On fault: RSP_FAULT_OUT=1 and RSP_INST_OUT=NOP_INST. Otherwise RSP_FAULT_OUT=0 and RSP_INST_OUT=mem[addr[31:2]].
- RESP:
  - RSP_INST_OUT, RSP_ADDR_OUT and RSP_FAULT_OUT are held stable while RSP_READY_IN=0.
  - On RSP_VALID_OUT && RSP_READY_IN: if a new request is accepted in the same cycle, go to WAIT or RESP per the accept rule (back-to-back fetch, full throughput when WAIT_STATES=0). Otherwise go to IDLE and clear RSP_VALID_OUT.
- FLUSH_IN=1 (highest priority after reset):
  - Next state IDLE, RSP_VALID_OUT=0.
  - Any request presented in the same cycle is not accepted (REQ_READY_OUT=0).
  - The requester re-issues the redirected PC on the following cycle.
- Program-load port:
  - On PROG_WE_IN, write mem[PROG_ADDR_IN[31:2]] <= PROG_DATA_IN; writes to out-of-range indices are dropped.
  - Writes are allowed in any state.
  - A write to the same word on the cycle the read is captured (entry to RESP) returns the old data; a held RESP word is not updated.
- Back-pressure never drops or duplicates a response. Exactly one response is returned per accepted, non-flushed request, and responses return in acceptance order (at most one outstanding).

Decomposition:
- Shared package: state encoding (IDLE/WAIT/RESP), the NOP_INST constant, and an instruction-word width constant of 32.
- One natural sub-module: rv32i_imem_array. It is a synchronous-write, combinational-read word array of DEPTH_WORDS entries with one read port and one write port. The FSM, counter, fault check and output registers stay in the top.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-WAIT after a request to 0x8.
  - Required response: RSP_VALID_OUT=0 immediately (async); RSP_INST_OUT=0x00000013; REQ_READY_OUT=1 after deassert; no response for 0x8 ever appears.
- Basic fetch:
  - Stimulus: WAIT_STATES=1; program mem[2]=0x00500093; request 0x8 with RSP_READY_IN=1.
  - Required response: RSP_VALID_OUT rises 2 cycles after accept with RSP_INST_OUT=0x00500093, RSP_ADDR_OUT=0x8, FAULT=0.
- Back-pressure and back-to-back:
  - Stimulus: WAIT_STATES=0; hold RSP_READY_IN=0 for 3 cycles after a response to 0x0, then raise it while REQ_VALID_IN=1 with 0x4.
  - Required response: response to 0x0 held stable for 3 cycles; 0x4 accepted on the handshake cycle; its response valid on the next cycle.
- Faults:
  - Stimulus: request 0x6, then request DEPTH_WORDS*4.
  - Required response: both return RSP_FAULT_OUT=1 and RSP_INST_OUT=0x00000013 with correct RSP_ADDR_OUT.
- Flush:
  - Stimulus: WAIT_STATES=3; request 0x10; pulse FLUSH_IN one cycle later while REQ_VALID_IN=1 with 0x40.
  - Required response: 0x40 is not accepted in the flush cycle; no response for 0x10; 0x40 is accepted the next cycle and answered 4 cycles later.
- Program-load collision:
  - Stimulus: write 0xDEADBEEF to word 5 on the cycle the fetch of 0x14 enters RESP.
  - Required response: response carries the old word; a second fetch of 0x14 returns 0xDEADBEEF.

Source files
------------

// File: rtl/rv32i_imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
//   - INST_W   : instruction word width
//   - NOP_WORD : ADDI x0,x0,0, returned on faults and held at reset
//   - state_t  : responder FSM encoding
package rv32i_imem_responder_pkg;

    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no request held
        ST_WAIT = 2'd1,   // counting down wait states
        ST_RESP = 2'd2    // response held until the consumer takes it
    } state_t;

endpackage

// File: rtl/rv32i_imem_responder_if.sv
// Fetch-side bus between the IF stage (master) and the instruction-memory
// responder (slave).
//   REQ_*  : fetch request handshake and PC
//   RSP_*  : response handshake, instruction word, address and fault flag
//   FLUSH_IN : discard any in-flight or pending response
//   PROG_* : program-load write port
interface rv32i_imem_responder_if;
    import rv32i_imem_responder_pkg::*;

    logic              REQ_VALID_IN;
    logic              REQ_READY_OUT;
    logic [31:0]       REQ_ADDR_IN;
    logic              RSP_VALID_OUT;
    logic              RSP_READY_IN;
    logic [INST_W-1:0] RSP_INST_OUT;
    logic [31:0]       RSP_ADDR_OUT;
    logic              RSP_FAULT_OUT;
    logic              FLUSH_IN;
    logic              PROG_WE_IN;
    logic [31:0]       PROG_ADDR_IN;
    logic [INST_W-1:0] PROG_DATA_IN;

    modport master (
        output REQ_VALID_IN, REQ_ADDR_IN, RSP_READY_IN, FLUSH_IN,
               PROG_WE_IN, PROG_ADDR_IN, PROG_DATA_IN,
        input  REQ_READY_OUT, RSP_VALID_OUT, RSP_INST_OUT, RSP_ADDR_OUT,
               RSP_FAULT_OUT
    );

    modport slave (
        input  REQ_VALID_IN, REQ_ADDR_IN, RSP_READY_IN, FLUSH_IN,
               PROG_WE_IN, PROG_ADDR_IN, PROG_DATA_IN,
        output REQ_READY_OUT, RSP_VALID_OUT, RSP_INST_OUT, RSP_ADDR_OUT,
               RSP_FAULT_OUT
    );

endinterface

// File: rtl/rv32i_imem_array.sv
// Instruction word storage: synchronous write, combinational read.
//   clk   : write clock
//   we    : write enable (caller guarantees waddr is in range)
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (shows the pre-write word during a same-cycle write)
module rv32i_imem_array
    import rv32i_imem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rv32i_imem_responder.sv
// Instruction-fetch responder: accepts a PC, returns the instruction word
// WAIT_STATES+1 cycles after the accept cycle, with back-pressure on both
// sides, a flush that drops anything in flight, and a program-load port.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of rv32i_imem_responder_if
module rv32i_imem_responder
    import rv32i_imem_responder_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                WAIT_STATES = 1,
    parameter logic [INST_W-1:0] NOP_INST    = NOP_WORD
) (
    input  logic                     clk,
    input  logic                     rst,
    rv32i_imem_responder_if.slave    bus
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    function automatic logic in_range(input logic [31:0] a);
        return {2'b00, a[31:2]} < DEPTH_L;
    endfunction

    function automatic logic is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || !in_range(a);
    endfunction

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [31:0]       req_addr;
    logic              rsp_valid;
    logic [INST_W-1:0] rsp_inst;
    logic [31:0]       rsp_addr;
    logic              rsp_fault;

    logic              req_ready;
    logic              accept;
    logic              capture;
    logic [31:0]       cap_addr;
    logic              cap_fault;
    logic [INST_W-1:0] rd_word;
    logic              prog_we;

    // Byte-offset bits of the program address carry no information.
    logic unused_prog_lsb;
    assign unused_prog_lsb = ^bus.PROG_ADDR_IN[1:0];

    assign req_ready = !bus.FLUSH_IN &&
                       ((state == ST_IDLE) || ((state == ST_RESP) && bus.RSP_READY_IN));
    assign accept    = bus.REQ_VALID_IN && req_ready;

    // With zero wait states the word is read straight from the incoming PC
    // on the accept cycle; otherwise from the latched PC on the last wait cycle.
    assign cap_addr  = (state == ST_WAIT) ? req_addr : bus.REQ_ADDR_IN;
    assign cap_fault = is_fault(cap_addr);
    assign capture   = !bus.FLUSH_IN &&
                       (((state == ST_WAIT) && (wait_cnt == 4'd0)) || (accept && ZERO_WAIT));

    assign prog_we   = bus.PROG_WE_IN && in_range(bus.PROG_ADDR_IN);

    rv32i_imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (prog_we),
        .waddr (bus.PROG_ADDR_IN[IDX_W+1:2]),
        .wdata (bus.PROG_DATA_IN),
        .raddr (cap_addr[IDX_W+1:2]),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            req_addr  <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_inst  <= NOP_INST;
            rsp_addr  <= 32'd0;
            rsp_fault <= 1'b0;
        end else if (bus.FLUSH_IN) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b0;
        end else begin
            // Output registers change only on capture, so a held response
            // stays stable (and ignores program-load writes) under back-pressure.
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_addr  <= cap_addr;
                rsp_fault <= cap_fault;
                rsp_inst  <= cap_fault ? NOP_INST : rd_word;
            end else if ((state == ST_RESP) && bus.RSP_READY_IN) begin
                rsp_valid <= 1'b0;
            end

            if (accept) begin
                req_addr <= bus.REQ_ADDR_IN;
                wait_cnt <= WAIT_INIT;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ZERO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.RSP_READY_IN) begin
                        if (accept) begin
                            state <= ZERO_WAIT ? ST_RESP : ST_WAIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.REQ_READY_OUT = req_ready;
    assign bus.RSP_VALID_OUT = rsp_valid;
    assign bus.RSP_INST_OUT  = rsp_inst;
    assign bus.RSP_ADDR_OUT  = rsp_addr;
    assign bus.RSP_FAULT_OUT = rsp_fault;

endmodule

// File: tb/tb_rv32i_imem_responder.sv
module tb_rv32i_imem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus, fanned out to three responders with different latencies.
    logic        req_valid = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic        rsp_ready = 1'b1;
    logic        flush     = 1'b0;
    logic        prog_we   = 1'b0;
    logic [31:0] prog_addr = 32'd0;
    logic [31:0] prog_data = 32'd0;

    rv32i_imem_responder_if if1 ();
    rv32i_imem_responder_if if0 ();
    rv32i_imem_responder_if if3 ();

    assign if1.REQ_VALID_IN = req_valid;  assign if0.REQ_VALID_IN = req_valid;  assign if3.REQ_VALID_IN = req_valid;
    assign if1.REQ_ADDR_IN  = req_addr;   assign if0.REQ_ADDR_IN  = req_addr;   assign if3.REQ_ADDR_IN  = req_addr;
    assign if1.RSP_READY_IN = rsp_ready;  assign if0.RSP_READY_IN = rsp_ready;  assign if3.RSP_READY_IN = rsp_ready;
    assign if1.FLUSH_IN     = flush;      assign if0.FLUSH_IN     = flush;      assign if3.FLUSH_IN     = flush;
    assign if1.PROG_WE_IN   = prog_we;    assign if0.PROG_WE_IN   = prog_we;    assign if3.PROG_WE_IN   = prog_we;
    assign if1.PROG_ADDR_IN = prog_addr;  assign if0.PROG_ADDR_IN = prog_addr;  assign if3.PROG_ADDR_IN = prog_addr;
    assign if1.PROG_DATA_IN = prog_data;  assign if0.PROG_DATA_IN = prog_data;  assign if3.PROG_DATA_IN = prog_data;

    rv32i_imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (.clk(clk), .rst(rst), .bus(if1));
    rv32i_imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst), .bus(if0));
    rv32i_imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst), .bus(if3));

    // Selected responder and its wait-state count.
    int ws = 1;

    logic        obs_ready, obs_valid, obs_fault;
    logic [31:0] obs_inst, obs_addr;
    always_comb begin
        obs_ready = if1.REQ_READY_OUT; obs_valid = if1.RSP_VALID_OUT;
        obs_inst  = if1.RSP_INST_OUT;  obs_addr  = if1.RSP_ADDR_OUT; obs_fault = if1.RSP_FAULT_OUT;
        if (ws == 0) begin
            obs_ready = if0.REQ_READY_OUT; obs_valid = if0.RSP_VALID_OUT;
            obs_inst  = if0.RSP_INST_OUT;  obs_addr  = if0.RSP_ADDR_OUT; obs_fault = if0.RSP_FAULT_OUT;
        end else if (ws == 3) begin
            obs_ready = if3.REQ_READY_OUT; obs_valid = if3.RSP_VALID_OUT;
            obs_inst  = if3.RSP_INST_OUT;  obs_addr  = if3.RSP_ADDR_OUT; obs_fault = if3.RSP_FAULT_OUT;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // At most one request outstanding; a response appears WAIT_STATES+1
    // cycles after its accept cycle and stays until handed over.
    typedef struct {
        logic        valid;
        logic        pend;
        int          due;
        logic [31:0] paddr;
        logic [31:0] inst;
        logic [31:0] addr;
        logic        fault;
    } mstate_t;

    mstate_t     m;
    logic [31:0] m_mem [DEPTH];

    function automatic logic model_ready(input mstate_t s);
        return !flush && ((!s.pend && !s.valid) || (s.valid && rsp_ready));
    endfunction

    function automatic mstate_t deliver(input mstate_t s, input logic [31:0] a);
        mstate_t n = s;
        n.valid = 1'b1;
        n.addr  = a;
        n.fault = (a % 4 != 0) || (a / 4 >= DEPTH);
        n.inst  = n.fault ? NOP : m_mem[a / 4];
        return n;
    endfunction

    function automatic mstate_t model_step(input mstate_t s);
        mstate_t n = s;
        logic    acc;
        if (flush) begin
            n.valid = 1'b0;
            n.pend  = 1'b0;
            return n;
        end
        acc = req_valid && model_ready(s);
        if (s.valid && rsp_ready) n.valid = 1'b0;
        if (s.pend) begin
            if (s.due == 0) begin
                n = deliver(n, s.paddr);
                n.pend = 1'b0;
            end else begin
                n.due = s.due - 1;
            end
        end
        if (acc) begin
            if (ws == 0) n = deliver(n, req_addr);
            else begin
                n.pend  = 1'b1;
                n.due   = ws - 1;
                n.paddr = req_addr;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '{valid: 1'b0, pend: 1'b0, due: 0, paddr: 32'd0, inst: NOP, addr: 32'd0, fault: 1'b0};
        end else begin
            m <= model_step(m);
            if (prog_we && (prog_addr / 4 < DEPTH)) m_mem[prog_addr / 4] <= prog_data;
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready", {31'd0, obs_ready}, {31'd0, model_ready(m)});
            check("rsp_valid", {31'd0, obs_valid}, {31'd0, m.valid});
            if (m.valid) begin
                check("rsp_inst",  obs_inst, m.inst);
                check("rsp_addr",  obs_addr, m.addr);
                check("rsp_fault", {31'd0, obs_fault}, {31'd0, m.fault});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int w);
        req_valid = 1'b0; flush = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
        ws  = w;
        rst = 1'b1;
        tick();
        check("rst_valid", {31'd0, obs_valid}, 32'd0);
        check("rst_inst",  obs_inst, NOP);
        check("rst_addr",  obs_addr, 32'd0);
        check("rst_fault", {31'd0, obs_fault}, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    // Presents a request, waits for the accept edge, then counts cycles
    // until the response is valid (1 = valid in the cycle after accept).
    task automatic request(input string name, input logic [31:0] a, output int lat);
        int cnt = 0;
        req_valid = 1'b1; req_addr = a;
        #1;
        while (!obs_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        if (!obs_ready) check({name, "_accept_timeout"}, 32'd0, 32'd1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!obs_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!obs_valid) check({name, "_rsp_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int seen;

        do_reset(1);
        prog(32'h00, 32'h0010_0093);
        prog(32'h04, 32'h0020_0113);
        prog(32'h08, 32'h0050_0093);
        prog(32'h14, 32'h00A0_0513);
        prog(32'h40, 32'h0400_006F);
        prog(32'h100, 32'hFFFF_FFFF);   // out of range, dropped

        // Reset asserted while a fetch of 0x8 is waiting.
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, obs_valid}, 32'd0);
        check("async_rst_inst",  obs_inst, NOP);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, obs_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (obs_valid) seen++;
            tick();
        end
        check("no_rsp_after_rst", seen, 0);

        // Basic fetch, one wait state.
        request("basic", 32'h8, lat);
        check("basic_lat",   lat, 2);
        check("basic_inst",  obs_inst, 32'h0050_0093);
        check("basic_addr",  obs_addr, 32'h8);
        check("basic_fault", {31'd0, obs_fault}, 32'd0);
        tick();

        // Faults: misaligned and out-of-range.
        request("misalign", 32'h6, lat);
        check("misalign_fault", {31'd0, obs_fault}, 32'd1);
        check("misalign_inst",  obs_inst, NOP);
        check("misalign_addr",  obs_addr, 32'h6);
        tick();
        request("oor", DEPTH * 4, lat);
        check("oor_fault", {31'd0, obs_fault}, 32'd1);
        check("oor_inst",  obs_inst, NOP);
        check("oor_addr",  obs_addr, 32'h100);
        tick();

        // Program-load collision on the capture cycle.
        req_valid = 1'b1; req_addr = 32'h14;
        tick();                                    // accepted
        req_valid = 1'b0;
        prog_we = 1'b1; prog_addr = 32'h14; prog_data = 32'hDEAD_BEEF;
        tick();                                    // capture edge
        prog_we = 1'b0;
        check("collide_valid", {31'd0, obs_valid}, 32'd1);
        check("collide_old",   obs_inst, 32'h00A0_0513);
        tick();
        request("refetch", 32'h14, lat);
        check("refetch_new", obs_inst, 32'hDEAD_BEEF);
        tick();

        // Back-pressure and back-to-back with zero wait states.
        do_reset(0);
        rsp_ready = 1'b0;
        request("bp", 32'h0, lat);
        check("bp_lat", lat, 1);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", {31'd0, obs_valid}, 32'd1);
            check("bp_hold_inst",  obs_inst, 32'h0010_0093);
            check("bp_hold_addr",  obs_addr, 32'h0);
            tick();
        end
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
        #1;
        check("b2b_accept", {31'd0, obs_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("b2b_valid", {31'd0, obs_valid}, 32'd1);
        check("b2b_addr",  obs_addr, 32'h4);
        check("b2b_inst",  obs_inst, 32'h0020_0113);
        tick();
        check("b2b_done", {31'd0, obs_valid}, 32'd0);

        // Flush during a three-wait-state fetch.
        do_reset(3);
        req_valid = 1'b1; req_addr = 32'h10;
        tick();                                    // 0x10 accepted
        flush = 1'b1; req_addr = 32'h40;
        #1;
        check("flush_blocks", {31'd0, obs_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("after_flush_ready", {31'd0, obs_ready}, 32'd1);
        tick();                                    // 0x40 accepted
        req_valid = 1'b0;
        lat = 1;
        while (!obs_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("flush_lat",  lat, 4);
        check("flush_addr", obs_addr, 32'h40);
        check("flush_inst", obs_inst, 32'h0400_006F);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
